vram_write_arb: RTL and testbench

VRAM_WRITE_ARB -- requirements
Module: vram_write_arb

---
 rtl/vram_write_arb_if.sv | 41 ++++
 rtl/vram_write_arb.sv | 152 +++++++++++++++
 tb/tb_vram_write_arb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_arb_if.sv
// Bundle of the CPU store port, rectangle-fill command/status and VRAM port-A write
// signals of vram_write_arb.
interface vram_write_arb_if;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 12;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;

    logic          fill_start;
    logic [XW-1:0] fill_x0;
    logic [XW-1:0] fill_x1;
    logic [YW-1:0] fill_y0;
    logic [YW-1:0] fill_y1;
    logic [DW-1:0] fill_color;
    logic          fill_busy;
    logic          fill_done;

    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data;

    // Requester side: CPU decoder / fill command source, also observes VRAM port.
    modport master (
        output cpu_we, cpu_addr, cpu_data,
        output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
        input  fill_busy, fill_done,
        input  vram_we, vram_addr, vram_data
    );

    // Arbiter side.
    modport slave (
        input  cpu_we, cpu_addr, cpu_data,
        input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
        output fill_busy, fill_done,
        output vram_we, vram_addr, vram_data
    );
endinterface

// File: rtl/vram_write_arb.sv
// VRAM port-A write arbiter: edge-detected CPU stores with strict priority over a
// rectangle-fill engine. Optional bound clamping with macro VRAM_ARB_CLIP_EN.
module vram_write_arb #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic           clk,
    input  logic           rst,
    vram_write_arb_if.slave bus
);
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 12;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    if (H_RES == 0 || V_RES == 0 || H_RES > 1024 || V_RES > 512) begin : g_bad_cfg
        $error("vram_write_arb: resolution does not fit the coordinate widths");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          cpu_we_q;
    logic          cpu_edge_c;
    logic [XW-1:0] x, x_next, x0, x0_next, x1, x1_next;
    logic [YW-1:0] y, y_next, y1, y1_next;
    logic [AW-1:0] rowbase, rowbase_next;
    logic [DW-1:0] color, color_next;
    logic          fill_wr_c;
    logic [AW-1:0] fill_addr_c;
    logic [XW-1:0] x0_lim_c, x1_lim_c;
    logic [YW-1:0] y0_lim_c, y1_lim_c;
    logic          empty_c;

    assign cpu_edge_c = bus.cpu_we & ~cpu_we_q;

`ifdef VRAM_ARB_CLIP_EN
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    // Clamp to the visible frame so a partially off-screen rectangle is cropped.
    always_comb begin
        x0_lim_c = (bus.fill_x0 > X_MAX) ? X_MAX : bus.fill_x0;
        x1_lim_c = (bus.fill_x1 > X_MAX) ? X_MAX : bus.fill_x1;
        y0_lim_c = (bus.fill_y0 > Y_MAX) ? Y_MAX : bus.fill_y0;
        y1_lim_c = (bus.fill_y1 > Y_MAX) ? Y_MAX : bus.fill_y1;
    end
`else
    assign x0_lim_c = bus.fill_x0;
    assign x1_lim_c = bus.fill_x1;
    assign y0_lim_c = bus.fill_y0;
    assign y1_lim_c = bus.fill_y1;
`endif

    assign empty_c     = (x0_lim_c > x1_lim_c) || (y0_lim_c > y1_lim_c);
    assign fill_addr_c = rowbase + AW'(x);

    // Fill FSM next-state; the only multiply happens once at command latch time.
    always_comb begin
        state_next   = state;
        x_next       = x;
        y_next       = y;
        x0_next      = x0;
        x1_next      = x1;
        y1_next      = y1;
        rowbase_next = rowbase;
        color_next   = color;
        fill_wr_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    x0_next      = x0_lim_c;
                    x1_next      = x1_lim_c;
                    y1_next      = y1_lim_c;
                    x_next       = x0_lim_c;
                    y_next       = y0_lim_c;
                    rowbase_next = AW'(y0_lim_c * H_RES);
                    color_next   = bus.fill_color;
                    state_next   = empty_c ? DONE : FILL;
                end
            end
            FILL: begin
                // A CPU store owns the port this cycle; the engine holds its pixel.
                if (!cpu_edge_c) begin
                    fill_wr_c = 1'b1;
                    if (x == x1) begin
                        if (y == y1) begin
                            state_next = DONE;
                        end else begin
                            x_next       = x0;
                            y_next       = y + YW'(1);
                            rowbase_next = rowbase + AW'(H_RES);
                        end
                    end else begin
                        x_next = x + XW'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            // Track the level so a strobe already high at reset release is not an edge.
            cpu_we_q      <= bus.cpu_we;
            x             <= '0;
            y             <= '0;
            x0            <= '0;
            x1            <= '0;
            y1            <= '0;
            rowbase       <= '0;
            color         <= '0;
            bus.vram_we   <= 1'b0;
            bus.vram_addr <= '0;
            bus.vram_data <= '0;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b0;
        end else begin
            state         <= state_next;
            cpu_we_q      <= bus.cpu_we;
            x             <= x_next;
            y             <= y_next;
            x0            <= x0_next;
            x1            <= x1_next;
            y1            <= y1_next;
            rowbase       <= rowbase_next;
            color         <= color_next;
            bus.vram_we   <= cpu_edge_c | fill_wr_c;
            if (cpu_edge_c) begin
                bus.vram_addr <= bus.cpu_addr;
                bus.vram_data <= bus.cpu_data;
            end else if (fill_wr_c) begin
                bus.vram_addr <= fill_addr_c;
                bus.vram_data <= color;
            end
            bus.fill_busy <= (state_next != IDLE);
            bus.fill_done <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_vram_write_arb.sv
// Scoreboard bench for vram_write_arb: stimulus pushes expected VRAM writes and
// fill_done events; a negedge monitor pops and compares them.
module tb_vram_write_arb;
    logic clk;
    logic rst;

    vram_write_arb_if bus ();

    vram_write_arb #(.H_RES(640), .V_RES(480)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic        chk_gap;
        logic [18:0] addr;
        logic [11:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_wr = -10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [18:0] a, input logic [11:0] d);
        exp_q.push_back('{is_done: 1'b0, chk_gap: 1'b0, addr: a, data: d});
    endtask

    task automatic push_done(input logic gap);
        exp_q.push_back('{is_done: 1'b1, chk_gap: gap, addr: '0, data: '0});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name, input int max);
        int t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected events still pending after %0d cycles",
                     name, exp_q.size(), max);
            exp_q.delete();
        end
    endtask

    // Called at a negedge; returns at the negedge after the start pulse was sampled.
    task automatic start_fill(input logic [9:0] x0, input logic [9:0] x1,
                              input logic [8:0] y0, input logic [8:0] y1,
                              input logic [11:0] color);
        bus.fill_x0    = x0;
        bus.fill_x1    = x1;
        bus.fill_y0    = y0;
        bus.fill_y1    = y1;
        bus.fill_color = color;
        bus.fill_start = 1'b1;
        @(negedge clk);
        bus.fill_start = 1'b0;
    endtask

    // Monitor: every VRAM write and fill_done pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.vram_we === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, none required",
                             bus.vram_addr, bus.vram_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done || bus.vram_addr !== e.addr || bus.vram_data !== e.data) begin
                        n_err++;
                        $display("FAIL write: got addr %0d data %0h, required %s addr %0d data %0h",
                                 bus.vram_addr, bus.vram_data, e.is_done ? "fill_done" : "write",
                                 e.addr, e.data);
                    end
                end
                last_wr = cyc;
            end
            if (bus.fill_done === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: fill_done pulsed, none required");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        n_err++;
                        $display("FAIL done_order: got fill_done, required write addr %0d data %0h",
                                 e.addr, e.data);
                    end else if (e.chk_gap && (cyc - last_wr) != 1) begin
                        n_err++;
                        $display("FAIL done_latency: got %0d cycles after last write, required 1",
                                 cyc - last_wr);
                    end
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 19'h12345;
        bus.cpu_data   = 12'h777;
        bus.fill_start = 1'b0;
        bus.fill_x0    = '0;
        bus.fill_x1    = '0;
        bus.fill_y0    = '0;
        bus.fill_y1    = '0;
        bus.fill_color = '0;
        rst            = 1'b1;

        // Reset values, with cpu_we held high across reset release (no write allowed).
        cycles(3);
        chk("rst_vram_we",   32'(bus.vram_we),   32'd0);
        chk("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
        chk("rst_vram_data", 32'(bus.vram_data), 32'd0);
        chk("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
        chk("rst_fill_done", 32'(bus.fill_done), 32'd0);
        rst = 1'b0;
        cycles(5);
        bus.cpu_we = 1'b0;
        cycles(2);

        // Long CPU strobe: exactly one write, one cycle after the edge.
        bus.cpu_addr = 19'h00100;
        bus.cpu_data = 12'hF00;
        push_wr(19'h00100, 12'hF00);
        bus.cpu_we = 1'b1;
        @(negedge clk);
        chk("cpu_lat_we",   32'(bus.vram_we),   32'd1);
        chk("cpu_lat_addr", 32'(bus.vram_addr), 32'h100);
        chk("cpu_lat_data", 32'(bus.vram_data), 32'hF00);
        @(negedge clk);
        chk("cpu_single_pulse", 32'(bus.vram_we), 32'd0);
        cycles(48);
        bus.cpu_we = 1'b0;
        drain("cpu_hold", 10);
        cycles(2);

        // Plain 3x2 fill at (2,1)-(4,2).
        push_wr(19'd642, 12'h0F0);  push_wr(19'd643, 12'h0F0);  push_wr(19'd644, 12'h0F0);
        push_wr(19'd1282, 12'h0F0); push_wr(19'd1283, 12'h0F0); push_wr(19'd1284, 12'h0F0);
        push_done(1'b1);
        start_fill(10'd2, 10'd4, 9'd1, 9'd2, 12'h0F0);
        chk("fill_busy_rise", 32'(bus.fill_busy), 32'd1);
        drain("fill_basic", 40);
        cycles(1);
        chk("fill_busy_fall", 32'(bus.fill_busy), 32'd0);
        cycles(2);

        // CPU store arriving mid-fill stalls the second pixel.
        bus.cpu_addr = 19'd5;
        bus.cpu_data = 12'hABC;
        push_wr(19'd642, 12'h0F0);  push_wr(19'd5, 12'hABC);    push_wr(19'd643, 12'h0F0);
        push_wr(19'd644, 12'h0F0);  push_wr(19'd1282, 12'h0F0); push_wr(19'd1283, 12'h0F0);
        push_wr(19'd1284, 12'h0F0); push_done(1'b1);
        start_fill(10'd2, 10'd4, 9'd1, 9'd2, 12'h0F0);
        @(negedge clk);
        bus.cpu_we = 1'b1;
        @(negedge clk);
        bus.cpu_we = 1'b0;
        drain("fill_cpu_stall", 40);
        cycles(2);

        // Inverted bounds: no writes, fill_done, busy at most one cycle.
        push_done(1'b0);
        start_fill(10'd10, 10'd3, 9'd0, 9'd0, 12'h111);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.fill_busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk("empty_busy_le1", 32'(busy_cnt <= 1), 32'd1);
        drain("empty_fill", 5);

        // Reset after the third fill write aborts the fill silently.
        push_wr(19'd642, 12'h0F0); push_wr(19'd643, 12'h0F0); push_wr(19'd644, 12'h0F0);
        start_fill(10'd2, 10'd4, 9'd1, 9'd2, 12'h0F0);
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_vram_we",   32'(bus.vram_we),   32'd0);
        chk("abort_vram_addr", 32'(bus.vram_addr), 32'd0);
        chk("abort_fill_busy", 32'(bus.fill_busy), 32'd0);
        rst = 1'b0;
        cycles(8);
        drain("abort_prefix", 2);
        push_wr(19'd0, 12'h00F); push_wr(19'd1, 12'h00F); push_done(1'b1);
        start_fill(10'd0, 10'd1, 9'd0, 9'd0, 12'h00F);
        drain("fill_after_abort", 20);
        cycles(2);

        // CPU edge and fill_start together: CPU write first.
        bus.cpu_addr = 19'd7;
        bus.cpu_data = 12'h123;
        push_wr(19'd7, 12'h123); push_wr(19'd0, 12'hFFF); push_done(1'b1);
        bus.cpu_we = 1'b1;
        start_fill(10'd0, 10'd0, 9'd0, 9'd0, 12'hFFF);
        bus.cpu_we = 1'b0;
        drain("cpu_and_start", 20);
        cycles(2);

        // fill_start during a busy fill is ignored.
        push_wr(19'd1920, 12'h0AA); push_wr(19'd1921, 12'h0AA); push_wr(19'd1922, 12'h0AA);
        push_done(1'b1);
        start_fill(10'd0, 10'd2, 9'd3, 9'd3, 12'h0AA);
        @(negedge clk);
        start_fill(10'd5, 10'd5, 9'd0, 9'd0, 12'h555);
        drain("start_while_busy", 20);
        cycles(6);

`ifdef VRAM_ARB_CLIP_EN
        // Bounds past the frame edge are clamped to the last column/row.
        push_wr(19'd307198, 12'hC3C); push_wr(19'd307199, 12'hC3C); push_done(1'b1);
        start_fill(10'd638, 10'd700, 9'd479, 9'd500, 12'hC3C);
`else
        // Without clamping, columns past the frame edge are written as computed.
        push_wr(19'd307198, 12'hC3C); push_wr(19'd307199, 12'hC3C);
        push_wr(19'd307200, 12'hC3C); push_wr(19'd307201, 12'hC3C); push_done(1'b1);
        start_fill(10'd638, 10'd641, 9'd479, 9'd479, 12'hC3C);
`endif
        drain("edge_fill", 20);
        cycles(5);
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
